// File: rtl/trace_stream_receiver.sv
// trace_stream_receiver: AXI-Stream trace sink with beat FIFO, framing check and saturating statistics
module trace_stream_receiver #(
  parameter int XLEN            = 64,
  parameter int AXI_DATA_WIDTH  = XLEN + 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int STAT_ADDR_WIDTH = 8
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       S_AXIS_tvalid,
  output logic                       S_AXIS_tready,
  input  logic [AXI_DATA_WIDTH-1:0]  S_AXIS_tdata,
  input  logic                       S_AXIS_tlast,
  input  logic [31:0]                tlast_interval,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic                       out_last,
  input  logic                       stats_clear,
  input  logic [STAT_ADDR_WIDTH-1:0] stat_addr,
  output logic [63:0]                stat_rdata
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  logic [AXI_DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] fill, fill_next;
  logic push, pop, is_wfi, good, early, missing, stall, wfi_seen;
  logic [31:0] beat_in_frame, pos, frames, early_tlast, missing_tlast, stall_cycles;
  logic [63:0] beats, stat_sel;
  assign push      = S_AXIS_tvalid & S_AXIS_tready;
  assign pop       = out_valid & out_ready;
  assign stall     = S_AXIS_tvalid & ~S_AXIS_tready;
  assign fill_next = fill + FW'(push) - FW'(pop);
  assign out_valid = fill != '0;
  assign {out_last, out_pc, out_instr} = mem[rd_ptr];
  assign is_wfi    = S_AXIS_tdata[31:0] == 32'h0000_0001;
  assign pos       = beat_in_frame + 32'd1;
  assign good      = push & S_AXIS_tlast & (pos == tlast_interval | is_wfi | tlast_interval == '0);
  assign early     = push & S_AXIS_tlast & ~good;
  assign missing   = push & ~S_AXIS_tlast & tlast_interval != '0 & pos == tlast_interval;
  // Beat storage; contents need no reset since fill gates visibility
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {S_AXIS_tlast, S_AXIS_tdata};
  // FIFO pointers, fill and registered ready (drops the cycle the FIFO fills)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill          <= '0;
      S_AXIS_tready <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr + AW'(push);
      rd_ptr        <= rd_ptr + AW'(pop);
      fill          <= fill_next;
      S_AXIS_tready <= fill_next < FW'(FIFO_DEPTH);
    end
  end
  // Frame position tracking; tlast or a missing-tlast resync restarts the frame
  always_ff @(posedge clk) begin
    if (rst) beat_in_frame <= '0;
    else if (push) beat_in_frame <= (S_AXIS_tlast | missing) ? '0 : pos;
  end
  // Saturating statistics; clear takes priority over any increment
  always_ff @(posedge clk) begin
    if (rst | stats_clear) begin
      beats         <= '0;
      frames        <= '0;
      early_tlast   <= '0;
      missing_tlast <= '0;
      stall_cycles  <= '0;
      wfi_seen      <= 1'b0;
    end else begin
      beats         <= beats + 64'(push & ~&beats);
      frames        <= frames + 32'((good | early) & ~&frames);
      early_tlast   <= early_tlast + 32'(early & ~&early_tlast);
      missing_tlast <= missing_tlast + 32'(missing & ~&missing_tlast);
      stall_cycles  <= stall_cycles + 32'(stall & ~&stall_cycles);
      wfi_seen      <= wfi_seen | (push & is_wfi);
    end
  end
  // Status mux
  always_comb begin
    stat_sel = stat_addr == STAT_ADDR_WIDTH'(0) ? beats :
               stat_addr == STAT_ADDR_WIDTH'(1) ? {32'b0, frames} :
               stat_addr == STAT_ADDR_WIDTH'(2) ? {32'b0, early_tlast} :
               stat_addr == STAT_ADDR_WIDTH'(3) ? {32'b0, missing_tlast} :
               stat_addr == STAT_ADDR_WIDTH'(4) ? {32'b0, stall_cycles} :
               stat_addr == STAT_ADDR_WIDTH'(5) ? {wfi_seen, {(63-FW){1'b0}}, fill} : 64'b0;
  end
  // Registered status read
  always_ff @(posedge clk) begin
    if (rst) stat_rdata <= '0;
    else stat_rdata <= stat_sel;
  end
endmodule

// File: tb/tb_trace_stream_receiver.sv
// tb_trace_stream_receiver: directed and random checks against a queue-based reference model
module tb_trace_stream_receiver;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1;
  logic s_tvalid = 0, s_tready, s_tlast = 0;
  logic [95:0] s_tdata = '0;
  logic [31:0] tlast_interval = 0;
  logic out_valid, out_ready = 0, out_last;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic stats_clear = 0;
  logic [7:0] stat_addr = 0;
  logic [63:0] stat_rdata;
  int checks = 0, errors = 0;

  trace_stream_receiver dut (
    .clk(clk), .rst(rst),
    .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready), .S_AXIS_tdata(s_tdata), .S_AXIS_tlast(s_tlast),
    .tlast_interval(tlast_interval),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .out_last(out_last),
    .stats_clear(stats_clear), .stat_addr(stat_addr), .stat_rdata(stat_rdata)
  );

  always #5 clk = ~clk;

  logic [96:0] q[$];
  logic m_tready = 0, m_wfi = 0;
  longint unsigned m_beats = 0;
  int unsigned m_frames = 0, m_early = 0, m_missing = 0, m_stall = 0, m_bif = 0;
  logic [63:0] m_rdata = 0;

  function automatic int unsigned sat(int unsigned v);
    return v == 32'hFFFF_FFFF ? v : v + 1;
  endfunction

  task automatic zero_stats();
    m_beats = 0; m_frames = 0; m_early = 0; m_missing = 0; m_stall = 0; m_wfi = 0;
  endtask

  task automatic model_step();
    bit acc, popm;
    int unsigned p;
    if (rst) begin
      q.delete(); m_tready = 0; m_bif = 0; m_rdata = 0; zero_stats();
      return;
    end
    case (stat_addr)
      0: m_rdata = m_beats;
      1: m_rdata = 64'(m_frames);
      2: m_rdata = 64'(m_early);
      3: m_rdata = 64'(m_missing);
      4: m_rdata = 64'(m_stall);
      5: m_rdata = {m_wfi, 63'(q.size())};
      default: m_rdata = 0;
    endcase
    acc = s_tvalid && m_tready;
    popm = q.size() != 0 && out_ready;
    if (s_tvalid && !m_tready) m_stall = sat(m_stall);
    if (acc) begin
      m_beats = m_beats == 64'hFFFF_FFFF_FFFF_FFFF ? m_beats : m_beats + 1;
      p = m_bif + 1;
      if (s_tlast) begin
        m_frames = sat(m_frames);
        if (!(p == tlast_interval || s_tdata[31:0] == 1 || tlast_interval == 0)) m_early = sat(m_early);
        m_bif = 0;
      end else if (tlast_interval != 0 && p == tlast_interval) begin
        m_missing = sat(m_missing);
        m_bif = 0;
      end else m_bif = p;
      if (s_tdata[31:0] == 1) m_wfi = 1;
    end
    if (popm) void'(q.pop_front());
    if (acc) q.push_back({s_tlast, s_tdata});
    m_tready = q.size() < DEPTH;
    if (stats_clear) zero_stats();
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("tready", 128'(s_tready), 128'(m_tready));
    chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
    if (q.size() != 0) chk("head", 128'({out_last, out_pc, out_instr}), 128'(q[0]));
    chk("stat_rdata", 128'(stat_rdata), 128'(m_rdata));
  endtask

  task automatic send(input logic [63:0] pc, input logic [31:0] instr, input logic last);
    bit acc;
    s_tvalid = 1; s_tdata = {pc, instr}; s_tlast = last;
    for (int i = 0; i < 50; i++) begin
      acc = m_tready;
      tick();
      if (acc) begin
        s_tvalid = 0; s_tlast = 0;
        return;
      end
    end
    chk("send_timeout", 128'(1), 128'(0));
    s_tvalid = 0; s_tlast = 0;
  endtask

  task automatic read_stat(input logic [7:0] a, input string tag, input logic [63:0] exp);
    stat_addr = a;
    tick();
    chk(tag, 128'(stat_rdata), 128'(exp));
  endtask

  task automatic clear();
    stats_clear = 1; tick(); stats_clear = 0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_tready", 128'(s_tready), 128'(0));
    chk("rst_valid", 128'(out_valid), 128'(0));
    rst = 0;
    tick();
    chk("post_rst_tready", 128'(s_tready), 128'(1));
    // 1: two well-formed frames of four
    tlast_interval = 4; out_ready = 1;
    for (int i = 1; i <= 8; i++) send(64'h8000_0000 + 64'(i * 4), 32'h100 + 32'(i), i % 4 == 0);
    tick(); tick();
    read_stat(1, "t1_frames", 2);
    read_stat(2, "t1_early", 0);
    read_stat(3, "t1_missing", 0);
    read_stat(0, "t1_beats", 8);
    // 2: backpressure with consumer stalled
    clear(); tlast_interval = 0; out_ready = 0;
    for (int i = 1; i <= 4; i++) send(64'h9000 + 64'(i), 32'h200 + 32'(i), 0);
    chk("t2_full_tready", 128'(s_tready), 128'(0));
    s_tvalid = 1; s_tdata = {64'h9005, 32'h205}; s_tlast = 0;
    stat_addr = 0;
    tick(); tick(); tick();
    chk("t2_beats", 128'(stat_rdata), 128'(4));
    stat_addr = 4; tick();
    chk("t2_stall", 128'(stat_rdata), 128'(3));
    out_ready = 1;
    send(64'h9005, 32'h205, 0);
    send(64'h9006, 32'h206, 0);
    for (int i = 0; i < 6; i++) tick();
    read_stat(0, "t2_beats_all", 6);
    // 3: early tlast, then WFI-terminated short frame
    clear(); tlast_interval = 4;
    send(1, 32'h13, 0); send(2, 32'h13, 1);
    tick();
    read_stat(2, "t3_early1", 1);
    send(3, 32'h13, 0); send(4, 32'h1, 1);
    tick();
    read_stat(2, "t3_early_hold", 1);
    read_stat(5, "t3_wfi", 64'h8000_0000_0000_0000);
    // 4: missing tlast resync
    clear(); tlast_interval = 3;
    for (int i = 0; i < 3; i++) send(64'(i), 32'h33, 0);
    for (int i = 0; i < 3; i++) send(64'(i), 32'h33, i == 2);
    tick();
    read_stat(3, "t4_missing", 1);
    read_stat(2, "t4_early", 0);
    read_stat(1, "t4_frames", 1);
    // 5: clear coincident with tlast accept
    clear(); tlast_interval = 0; out_ready = 0;
    send(10, 32'h44, 0);
    stats_clear = 1;
    send(11, 32'h45, 1);
    stats_clear = 0;
    read_stat(1, "t5_frames", 0);
    read_stat(5, "t5_fill", 2);
    // 6: reset with beats buffered
    send(12, 32'h46, 0);
    rst = 1; tick();
    chk("t6_valid", 128'(out_valid), 128'(0));
    chk("t6_tready", 128'(s_tready), 128'(0));
    tick();
    rst = 0; tick();
    chk("t6_tready_up", 128'(s_tready), 128'(1));
    chk("t6_rdata", 128'(stat_rdata), 128'(0));
    // random traffic
    for (int n = 0; n < 600; n++) begin
      s_tvalid = $urandom_range(0, 3) != 0;
      s_tlast = $urandom_range(0, 3) == 0;
      s_tdata = {32'($urandom), 32'($urandom), $urandom_range(0, 7) == 0 ? 32'h1 : 32'($urandom)};
      out_ready = $urandom_range(0, 2) != 0;
      stat_addr = 8'($urandom_range(0, 7));
      stats_clear = $urandom_range(0, 40) == 0;
      rst = $urandom_range(0, 150) == 0;
      if ($urandom_range(0, 30) == 0) tlast_interval = $urandom_range(0, 5);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
